// File: rtl/eth_rx_deframer.sv
// RMII receive deframer: strips preamble/SFD, assembles bytes, checks FCS/length/alignment.
// Optional ETH_RX_MAC_FILTER_EN diverts frames whose destination is neither MY_MAC nor broadcast.
module eth_rx_deframer #(
    parameter int          MIN_LEN = 64,
    parameter int          MAX_LEN = 1518,
    parameter logic [47:0] MY_MAC  = 48'h02_00_00_00_00_01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rmii_crs_dv,
    input  logic [1:0]  rmii_rxd,
    output logic        wr_en,
    output logic [15:0] wr_idx,
    output logic [7:0]  wr_byte,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [15:0] frame_len,
    output logic        busy
);

    typedef enum logic [2:0] {S_IDLE, S_PREAM, S_DATA, S_END, S_DROP} state_t;

    state_t      st, st_nx;
    logic [5:0]  cur;
    logic [1:0]  bitp;
    logic [15:0] cnt;
    logic [31:0] crc;
    logic [7:0]  byte_asm;
    logic        do_start, do_byte, do_judge, do_ovf, mac_drop, good;
    logic [15:0] len_sat;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign byte_asm = {rmii_rxd, cur};
    assign len_sat  = (cnt < 16'd4) ? 16'd0 : cnt - 16'd4;
    assign good     = (crc == 32'hDEBB20E3) && (cnt >= 16'(MIN_LEN)) &&
                      (cnt <= 16'(MAX_LEN)) && (bitp == 2'd0);

`ifdef ETH_RX_MAC_FILTER_EN
    logic [39:0] mac_sr;
    logic [47:0] dest;
    assign dest     = {mac_sr, byte_asm};
    assign mac_drop = (cnt == 16'd5) && (dest != MY_MAC) && (dest != 48'hFFFF_FFFF_FFFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mac_sr <= '0;
        else if (do_byte && cnt < 16'd5)
            mac_sr <= {mac_sr[31:0], byte_asm};
    end
`else
    logic unused_my_mac;
    assign unused_my_mac = ^MY_MAC;
    assign mac_drop      = 1'b0;
`endif

    always_comb begin
        st_nx    = st;
        do_start = 1'b0;
        do_byte  = 1'b0;
        do_judge = 1'b0;
        do_ovf   = 1'b0;
        case (st)
            S_IDLE:  if (rmii_crs_dv) st_nx = S_PREAM;
            S_PREAM: begin
                if (!rmii_crs_dv)
                    st_nx = S_IDLE;
                else if (rmii_rxd == 2'b11) begin
                    st_nx    = S_DATA;
                    do_start = 1'b1;
                end else if (rmii_rxd == 2'b10)
                    st_nx = S_DROP;
            end
            S_DATA: begin
                if (!rmii_crs_dv) begin
                    st_nx    = S_END;
                    do_judge = 1'b1;
                end else if (bitp == 2'd3) begin
                    // A byte beyond MAX_LEN is never written; the frame is judged now.
                    if (cnt == 16'(MAX_LEN)) begin
                        do_ovf = 1'b1;
                        st_nx  = S_DROP;
                    end else begin
                        do_byte = 1'b1;
                        if (mac_drop) st_nx = S_DROP;
                    end
                end
            end
            // Pulse is visible in this state; a new carrier may start right away.
            S_END:   st_nx = rmii_crs_dv ? S_PREAM : S_IDLE;
            S_DROP:  if (!rmii_crs_dv) st_nx = S_IDLE;
            default: st_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= S_IDLE;
            cur         <= '0;
            bitp        <= '0;
            cnt         <= '0;
            crc         <= 32'hFFFF_FFFF;
            wr_en       <= 1'b0;
            wr_idx      <= '0;
            wr_byte     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_len   <= '0;
            busy        <= 1'b0;
        end else begin
            st          <= st_nx;
            wr_en       <= do_byte;
            frame_valid <= do_judge && good;
            frame_err   <= (do_judge && !good) || do_ovf;
            if (do_start) begin
                bitp <= '0;
                cnt  <= '0;
                crc  <= 32'hFFFF_FFFF;
                busy <= 1'b1;
            end
            if (st == S_DATA && rmii_crs_dv) begin
                cur  <= byte_asm[7:2];
                bitp <= bitp + 2'd1;
            end
            if (do_byte) begin
                wr_byte <= byte_asm;
                wr_idx  <= cnt;
                cnt     <= cnt + 16'd1;
                crc     <= crc_byte(crc, byte_asm);
            end
            if (do_judge || do_ovf)
                frame_len <= len_sat;
            if (do_judge || st_nx == S_DROP)
                busy <= 1'b0;
        end
    end

endmodule
